east_link_rx: RTL

EAST_LINK_RX -- requirements
Module: east_link_rx

---
 rtl/east_link_if.sv | 21 ++
 rtl/east_link_rx.sv | 76 +++++++
 2 files changed

// File: rtl/east_link_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | east_link_if : one-direction flit link (valid/dest/payload + backpress)  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
interface east_link_if #(
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int D_W = 8
);
  logic           v;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [D_W-1:0] d;
  logic           b;

  // master sources flits and observes backpressure; slave does the reverse
  modport master (output v, output x, output y, output d, input b);
  modport slave  (input v, input x, input y, input d, output b);
endinterface
`default_nettype wire

// File: rtl/east_link_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | east_link_rx : show-ahead flit FIFO between east link and local router  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module east_link_rx #(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  east_link_if.slave                 up,
  east_link_if.master                dn,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ent_w = X_W + Y_W + D_W;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               in_b_q, in_b_d;
  logic               ovf_q, ovf_d;
  logic               push, pop;
  logic [c_ent_w-1:0] mem_q [DEPTH];

  always_comb begin
    push     = up.v && !in_b_q;
    pop      = (count_q != '0) && !dn.b;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // backpressure is registered from next occupancy so it never depends on this cycle's inputs
    in_b_d = (count_d == c_full);
    ovf_d  = ovf_q | (up.v & in_b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_b_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      in_b_q   <= in_b_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {up.x, up.y, up.d};
  end

  assign up.b                 = in_b_q;
  assign dn.v                 = (count_q != '0);
  assign {dn.x, dn.y, dn.d}   = mem_q[rd_ptr_q];
  assign count                = count_q;
  assign ovf                  = ovf_q;
endmodule
`default_nettype wire
